// File: rtl/mux_pkg.sv
// Shared constants, types and helpers for the round-robin arbitrated mux.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Occupancy of the output register
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Ceiling log2, used to size channel indices
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority or round-robin starting at ptr.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W    = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                mode,
    input  logic                en,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);

    logic found;

    // Scan channels from the start point and grant the first requester
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            int unsigned idx;
            idx = (mode == MODE_RR) ? (32'(ptr) + k) : k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (en && !found && req[SEL_W'(idx)]) begin
                found                 = 1'b1;
                grant[SEL_W'(idx)]    = 1'b1;
                grant_idx             = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel registered mux with valid/ready handshake and selectable arbitration.
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);

    out_state_e          state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic                load_en;
    logic                arb_en;
    logic                xfer;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .mode      (mode),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Output register occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state: reload or empty whenever the register can take a word
    always_comb begin
        state_d = state_q;
        if (load_en) begin
            state_d = xfer ? ST_FULL : ST_EMPTY;
        end
    end

    // Handshake and output decode; no grants are issued while reset is held
    always_comb begin
        load_en   = (state_q == ST_EMPTY) || out_ready;
        arb_en    = load_en && !rst;
        in_ready  = grant;
        xfer      = |(in_valid & grant);
        out_valid = (state_q == ST_FULL);
        out_data  = data_q;
        out_sel   = sel_q;
    end

    // Datapath next state: capture granted word, advance pointer in round-robin
    always_comb begin
        data_d = data_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        if (xfer) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (grant[i]) begin
                    data_d = in_data[i*WIDTH +: WIDTH];
                end
            end
            sel_d = grant_idx;
            if (mode == MODE_RR) begin
                ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= '0;
            ptr_q  <= '0;
        end else begin
            data_q <= data_d;
            sel_q  <= sel_d;
            ptr_q  <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus random traffic against a model.
module tb_rr_arb_mux;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_sel;
    logic            out_ready;

    int checks;
    int errors;

    // Reference state
    logic            m_valid;
    logic [W-1:0]    m_data;
    int              m_sel;
    int              m_ptr;

    rr_arb_mux #(
        .WIDTH    (W),
        .CHANNELS (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner among current requests, -1 if none
    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int c;
            c = mode ? (m_ptr + k) % N : k;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_clock();
        int g;
        if (rst) begin
            model_reset();
        end else if (!m_valid || out_ready) begin
            g = model_grant();
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_sel   = g;
                if (mode) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] exp_rdy;
        int g;
        exp_rdy = '0;
        if (!rst && (!m_valid || out_ready)) begin
            g = model_grant();
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        check("in_ready",  32'(in_ready),  32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  out_data,       m_data);
        check("out_sel",   32'(out_sel),   32'(m_sel));
    endtask

    // Called at a negedge after inputs are set; returns at the next negedge
    task automatic cycle();
        if (rst) model_reset();
        #1;
        compare();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_data(input int ch, input logic [W-1:0] v);
        in_data[ch*W +: W] = v;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 4'b1111;
        in_data   = '0;
        for (int i = 0; i < N; i++) set_data(i, $urandom);
        out_ready = 1'b1;

        // Reset with all channels requesting
        #2;
        check("rst_ready", 32'(in_ready),  32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data",  out_data,       32'h0);
        check("rst_sel",   32'(out_sel),   32'h0);
        @(negedge clk);
        cycle();
        rst = 1'b0;

        // Fixed priority: ch1 beats ch3 and keeps winning
        mode     = 1'b0;
        in_valid = 4'b1010;
        set_data(1, 32'h11);
        set_data(3, 32'h33);
        #1;
        check("fp_ready", 32'(in_ready), 32'h2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("fp_data",   out_data,       32'h11);
            check("fp_sel",    32'(out_sel),   32'h1);
            check("fp_starve", 32'(in_ready),  32'h2);
        end

        // Round-robin rotation with all requesting
        mode     = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_data(i, 32'h100 + 32'(i));
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rr_sel",  32'(out_sel), 32'(k % N));
            check("rr_data", out_data,     32'h100 + 32'(k % N));
        end

        // Back-pressure holds the word, then drain and reload together
        mode     = 1'b0;
        in_valid = 4'b0100;
        set_data(2, 32'hAAAA5555);
        cycle();
        set_data(2, 32'h12345678);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_data",  out_data,       32'hAAAA5555);
            check("bp_sel",   32'(out_sel),   32'h2);
            check("bp_ready", 32'(in_ready),  32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_reload_ready", 32'(in_ready), 32'h4);
        cycle();
        check("bp_reload_data", out_data, 32'h12345678);
        in_valid = 4'b0000;
        cycle();
        check("bp_drain_valid", 32'(out_valid), 32'h0);
        check("bp_drain_hold",  out_data,       32'h12345678);

        // Sparse request and pointer wrap
        mode     = 1'b1;
        in_valid = 4'b0100;
        cycle();
        check("wrap_sel2", 32'(out_sel), 32'h2);
        in_valid = 4'b0001;
        #1;
        check("wrap_ready0", 32'(in_ready), 32'h1);
        cycle();
        check("wrap_sel0", 32'(out_sel), 32'h0);
        in_valid = 4'b1111;
        #1;
        check("wrap_ptr1", 32'(in_ready), 32'h2);
        cycle();
        in_valid = 4'b0000;
        cycle();
        check("wrap_idle", 32'(out_valid), 32'h0);

        // Mode switch preserves the pointer
        in_valid = 4'b0100;
        cycle();
        mode     = 1'b0;
        in_valid = 4'b1001;
        #1;
        check("ms_fixed", 32'(in_ready), 32'h1);
        cycle();
        mode = 1'b1;
        #1;
        check("ms_rr", 32'(in_ready), 32'h8);
        cycle();
        check("ms_sel", 32'(out_sel), 32'h3);

        // Reset in the middle of a stream clears outputs at once
        in_valid = 4'b1111;
        cycle();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_data",  out_data,       32'h0);
        check("mid_rst_ready", 32'(in_ready),  32'h0);
        cycle();
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 149) == 0);
            mode      = $urandom_range(0, 3) != 0;
            in_valid  = N'($urandom);
            out_ready = $urandom_range(0, 9) < 7;
            for (int i = 0; i < N; i++) set_data(i, $urandom);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
